// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter controller and its rotator: shift-type
// and FSM encodings, rotate direction constant and a thermometer-mask helper.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'd0,
        SHIFT_LSR = 2'd1,
        SHIFT_ASR = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REG_CYC = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    localparam logic ROTATE_LEFT = 1'b1;

    // Bits [k-1:0] set; used to trim rotated data into logical/arithmetic shifts.
    function automatic logic [31:0] low_mask(input logic [4:0] k);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/barrel_shifter_32_multi.sv
// 32-bit combinational rotator; five log stages rotating right, left rotation
// handled by rotating right by (32 - amount).
module barrel_shifter_32_multi
    import shifter_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [4:0]  i_amt,
    input  logic        i_dir,
    output logic [31:0] o_data
);

    logic [4:0]  w_ramt;
    logic [31:0] w_rot;

    assign w_ramt = (i_dir == ROTATE_LEFT) ? (5'd0 - i_amt) : i_amt;

    always_comb begin
        w_rot = i_data;
        if (w_ramt[0]) w_rot = {w_rot[0],     w_rot[31:1]};
        if (w_ramt[1]) w_rot = {w_rot[1:0],   w_rot[31:2]};
        if (w_ramt[2]) w_rot = {w_rot[3:0],   w_rot[31:4]};
        if (w_ramt[3]) w_rot = {w_rot[7:0],   w_rot[31:8]};
        if (w_ramt[4]) w_rot = {w_rot[15:0],  w_rot[31:16]};
    end

    assign o_data = w_rot;

endmodule

// File: rtl/shifter_ctrl.sv
// Request/response controller around the rotator: captures a shift request,
// forms LSL/LSR/ASR/ROR/RRX results and holds them until the consumer accepts.
module shifter_ctrl
    import shifter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] operand,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  shift_amt,
    input  logic        imm_form,
    input  logic        carry_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic        carry_out
);

    state_e      r_state, w_state_next;
    logic [31:0] r_operand;
    shift_type_e r_type;
    logic [7:0]  r_amt;
    logic        r_imm;
    logic        r_cin;
    logic [31:0] r_result;
    logic        r_carry;

    logic        w_accept;
    logic        w_load;
    logic        w_live;
    logic [31:0] w_op;
    shift_type_e w_type;
    logic [7:0]  w_amt;
    logic        w_imm;
    logic        w_cin;
    logic [7:0]  w_n;
    logic        w_rrx;
    logic [31:0] w_rot;
    logic [31:0] w_keep;
    logic [31:0] w_res;
    logic        w_c;

    assign req_ready = (r_state == ST_IDLE);
    assign res_valid = (r_state == ST_HOLD);
    assign w_accept  = req_valid & req_ready;

    // Immediate requests finish in the accept cycle, so the datapath sees the
    // live request while idle and the captured copy during REG_CYC.
    assign w_live = (r_state == ST_IDLE);
    assign w_op   = w_live ? operand                   : r_operand;
    assign w_type = w_live ? shift_type_e'(shift_type) : r_type;
    assign w_amt  = w_live ? shift_amt                 : r_amt;
    assign w_imm  = w_live ? imm_form                  : r_imm;
    assign w_cin  = w_live ? carry_in                  : r_cin;

    always_comb begin
        w_rrx = 1'b0;
        w_n   = w_amt;
        if (w_imm) begin
            w_n = {3'b000, w_amt[4:0]};
            if (w_amt[4:0] == 5'd0) begin
                if (w_type == SHIFT_LSR || w_type == SHIFT_ASR) begin
                    w_n = 8'd32;
                end else if (w_type == SHIFT_ROR) begin
                    w_rrx = 1'b1;
                end
            end
        end
    end

    barrel_shifter_32_multi u_rot (
        .i_data (w_op),
        .i_amt  (w_n[4:0]),
        .i_dir  ((w_type == SHIFT_LSL) ? ROTATE_LEFT : ~ROTATE_LEFT),
        .o_data (w_rot)
    );

    // Right shifts by n keep the low (32 - n) bits of the rotated word.
    assign w_keep = low_mask(5'd0 - w_n[4:0]);

    always_comb begin
        w_res = w_op;
        w_c   = w_cin;
        unique case (w_type)
            SHIFT_LSL: begin
                if (w_n == 8'd0) begin
                    w_res = w_op;
                    w_c   = w_cin;
                end else if (w_n < 8'd32) begin
                    w_res = w_rot & ~low_mask(w_n[4:0]);
                    w_c   = w_rot[0];
                end else begin
                    w_res = 32'd0;
                    w_c   = (w_n == 8'd32) ? w_op[0] : 1'b0;
                end
            end
            SHIFT_LSR: begin
                if (w_n == 8'd0) begin
                    w_res = w_op;
                    w_c   = w_cin;
                end else if (w_n < 8'd32) begin
                    w_res = w_rot & w_keep;
                    w_c   = w_rot[31];
                end else begin
                    w_res = 32'd0;
                    w_c   = (w_n == 8'd32) ? w_op[31] : 1'b0;
                end
            end
            SHIFT_ASR: begin
                if (w_n == 8'd0) begin
                    w_res = w_op;
                    w_c   = w_cin;
                end else if (w_n < 8'd32) begin
                    w_res = (w_rot & w_keep) | ({32{w_op[31]}} & ~w_keep);
                    w_c   = w_rot[31];
                end else begin
                    w_res = {32{w_op[31]}};
                    w_c   = w_op[31];
                end
            end
            SHIFT_ROR: begin
                if (w_rrx) begin
                    w_res = {w_cin, w_op[31:1]};
                    w_c   = w_op[0];
                end else if (w_n == 8'd0) begin
                    w_res = w_op;
                    w_c   = w_cin;
                end else if (w_n[4:0] == 5'd0) begin
                    w_res = w_op;
                    w_c   = w_op[31];
                end else begin
                    w_res = w_rot;
                    w_c   = w_rot[31];
                end
            end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = imm_form ? ST_HOLD : ST_REG_CYC;
            end
            ST_REG_CYC: w_state_next = ST_HOLD;
            ST_HOLD: begin
                if (res_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_load = (w_accept & imm_form) | (r_state == ST_REG_CYC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_operand <= 32'd0;
            r_type    <= SHIFT_LSL;
            r_amt     <= 8'd0;
            r_imm     <= 1'b0;
            r_cin     <= 1'b0;
            r_result  <= 32'd0;
            r_carry   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_operand <= operand;
                r_type    <= shift_type_e'(shift_type);
                r_amt     <= shift_amt;
                r_imm     <= imm_form;
                r_cin     <= carry_in;
            end
            if (w_load) begin
                r_result <= w_res;
                r_carry  <= w_c;
            end
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry;

endmodule
